path_node_sequencer: RTL and testbench
======================================

// Module: path_node_sequencer
// PURPOSE
//  Parametrised path store and hop sequencer for the line-following bot.
//  Loads a packed node list and per-hop turn codes in a single cycle, then steps through them on node-detect events.
//  Presents the current node, next node and the motor action; a motor/line-follow block executes that action.
//  Replaces the fixed 36-entry hand-unpacked path array; adds length control, abort, error and done signalling.
// PARAMETERS
//  NODE_W     7    width of one node ID
//  MAX_NODES  37   path storage depth (entries)
//  IDX_W      $clog2(MAX_NODES+1)  index/length width (derived, localparam)
// PORTS
//  clk         in   1                  system clock
//  rst         in   1                  async active-high reset
//  path_in     in   NODE_W*MAX_NODES   packed node list; entry k = path_in[k*NODE_W +: NODE_W]
//  act_in      in   2*MAX_NODES        packed turn code for arrival at entry k = act_in[2k +: 2]
//  path_len    in   IDX_W              number of valid entries, 2..MAX_NODES
//  load        in   1                  1-cycle pulse: capture path_in/act_in/path_len
//  abort       in   1                  level: stop, return to IDLE
//  node_det    in   1                  level from sensor logic: node under bot (e.g. adc_data==3'b111)
//  turn_done   in   1                  1-cycle pulse from motor block: commanded turn completed
//  cur_node    out  NODE_W             last node reached
//  next_node   out  NODE_W             node being driven toward
//  action      out  2                  00 follow_line, 01 turn_R, 11 turn_L, 10 go_st
//  hop_idx     out  IDX_W              index of next_node in list
//  busy        out  1                  path in progress
//  done        out  1                  sticky: final node reached
//  err         out  1                  sticky: illegal load (bad length or load while busy)
// BEHAVIOUR
//  Reset: state IDLE; cur_node, next_node, hop_idx = 0; action = 00; busy, done, err = 0; store cleared.
//  States: IDLE, FOLLOW, TURN, DONE.
//  IDLE + load, 2<=path_len<=MAX_NODES: capture all inputs; next cycle FOLLOW, busy=1, done=0, err=0,
//   cur_node=entry0, next_node=entry1, hop_idx=1, action=00.
//  IDLE/DONE + load with path_len<2 or >MAX_NODES: err=1, no capture, state unchanged.
//  FOLLOW/TURN + load: ignored; err=1.
//  node_det is edge-detected internally (registered copy); only a 0->1 edge counts (ndet_rise).
//  FOLLOW + ndet_rise: cur_node<=next_node.
//   If hop_idx==len-1: DONE, busy=0, done=1, action=00 (no turn at the final node).
//   Else: action<=act[hop_idx]. Code 00 or 10: advance immediately, stay FOLLOW, action back to 00 one cycle later.
//   Code 01 or 11: enter TURN.
//  TURN: action held. On turn_done: hop_idx++, next_node<=entry[hop_idx+1], action=00, FOLLOW.
//   ndet_rise in TURN: ignored (the bot is still on the node).
//  turn_done outside TURN: ignored.
//  Advance = hop_idx<=hop_idx+1, next_node<=entry[hop_idx+1]; all outputs update on the same edge (1-cycle latency).
//  abort (any state, highest priority over load, ndet_rise, turn_done): next cycle IDLE, busy=0, action=00.
//   done and err are unchanged; the store is retained.
//  DONE: holds cur_node = final entry; a new legal load restarts the path.
//  Async rst mid-path: all outputs go to reset values immediately.
//  Duplicate consecutive node IDs are legal and treated as ordinary hops.
// STRUCTURE
//  Shared package (bot_pkg): action codes (FOLLOW_LINE, TURN_R, TURN_L, GO_ST), state enum, NODE_W default.
//  One sub-module: edge_rise_det (registered rising-edge detector, async reset), used for node_det.
//  Store: MAX_NODES x NODE_W register array plus a 2-bit action array; index muxing stays in this module.
// TESTING
//  1 load len=3, nodes {33,5,3}, acts {x,01,x} -> busy; cur=33, next=5; node edge -> action=01;
//    turn_done -> next=3; node edge -> done=1, busy=0.
//  2 len=4, all acts 10 -> three node edges, no TURN entered; action=10 for one cycle each, then done.
//  3 load len=1 and len=MAX_NODES+1 -> err=1, busy stays 0; then len=2 -> err clears, busy=1.
//  4 node_det held high for 10 cycles in FOLLOW -> exactly one hop; ndet edge during TURN -> no change.
//  5 abort together with load and turn_done in TURN -> IDLE next cycle, action=00; load while busy -> err=1, path unchanged.
//  6 rst asserted mid-TURN between clock edges -> outputs zero asynchronously; MAX_NODES=37, len=37 run completes, hop_idx=36.

Source files
------------

// File: rtl/bot_pkg.sv
// rtl/bot_pkg.sv - shared action codes, sequencer states and default sizes for the line-following bot
package bot_pkg;

   localparam int NODE_W_DEF    = 7;
   localparam int MAX_NODES_DEF = 37;

   typedef enum logic [1:0] {
      FOLLOW_LINE = 2'b00,
      TURN_R      = 2'b01,
      GO_ST       = 2'b10,
      TURN_L      = 2'b11
   } action_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FOLLOW = 2'b01,
      ST_TURN   = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   // Turn codes are the ones with bit 0 set; they wait for the motor block.
   function automatic logic is_turn(input logic [1:0] code);
      return code[0];
   endfunction

endpackage

// File: rtl/path_node_sequencer_if.sv
// rtl/path_node_sequencer_if.sv - path load, sensor/motor handshake and status bundle for the sequencer
interface path_node_sequencer_if import bot_pkg::*; #(
   parameter int NODE_W    = NODE_W_DEF,
   parameter int MAX_NODES = MAX_NODES_DEF
);
   localparam int IDX_W = $clog2(MAX_NODES + 1);

   logic [NODE_W*MAX_NODES-1:0] path_in;
   logic [2*MAX_NODES-1:0]      act_in;
   logic [IDX_W-1:0]            path_len;
   logic                        load;
   logic                        abort;
   logic                        node_det;
   logic                        turn_done;
   logic [NODE_W-1:0]           cur_node;
   logic [NODE_W-1:0]           next_node;
   logic [1:0]                  action;
   logic [IDX_W-1:0]            hop_idx;
   logic                        busy;
   logic                        done;
   logic                        err;

   modport master (
      output path_in, act_in, path_len, load, abort, node_det, turn_done,
      input  cur_node, next_node, action, hop_idx, busy, done, err
   );

   modport slave (
      input  path_in, act_in, path_len, load, abort, node_det, turn_done,
      output cur_node, next_node, action, hop_idx, busy, done, err
   );

endinterface

// File: rtl/edge_rise_det.sv
// rtl/edge_rise_det.sv - registered rising-edge detector; pulses for the cycle the input first reads high
module edge_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/path_node_sequencer.sv
// rtl/path_node_sequencer.sv - path store and hop sequencer; steps the loaded node list on node-detect edges
module path_node_sequencer import bot_pkg::*; #(
   parameter int NODE_W    = NODE_W_DEF,
   parameter int MAX_NODES = MAX_NODES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   path_node_sequencer_if.slave bus
);

   localparam int IDX_W = $clog2(MAX_NODES + 1);

   state_e            state_q, state_d;
   logic [NODE_W-1:0] node_q [MAX_NODES];
   logic [NODE_W-1:0] node_d [MAX_NODES];
   logic [1:0]        act_q  [MAX_NODES];
   logic [1:0]        act_d  [MAX_NODES];
   logic [IDX_W-1:0]  len_q, len_d;
   logic [NODE_W-1:0] cur_q, cur_d;
   logic [NODE_W-1:0] next_q, next_d;
   logic [IDX_W-1:0]  hop_q, hop_d;
   logic [1:0]        action_q, action_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              ndet_rise;
   logic [IDX_W-1:0]  hop_inc;
   logic [IDX_W-1:0]  last_idx;
   logic [NODE_W-1:0] nxt_entry;
   logic [1:0]        hop_act;
   logic              len_ok;

   edge_rise_det u_ndet (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (bus.node_det),
      .rise_o (ndet_rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         cur_q    <= '0;
         next_q   <= '0;
         hop_q    <= '0;
         action_q <= FOLLOW_LINE;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int k = 0; k < MAX_NODES; k++) begin
            node_q[k] <= '0;
            act_q[k]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cur_q    <= cur_d;
         next_q   <= next_d;
         hop_q    <= hop_d;
         action_q <= action_d;
         done_q   <= done_d;
         err_q    <= err_d;
         for (int k = 0; k < MAX_NODES; k++) begin
            node_q[k] <= node_d[k];
            act_q[k]  <= act_d[k];
         end
      end
   end

   // Index muxes: turn code for arrival at hop_q, and the node after it.
   always_comb begin
      hop_inc   = hop_q + IDX_W'(1);
      last_idx  = len_q - IDX_W'(1);
      nxt_entry = '0;
      hop_act   = FOLLOW_LINE;
      for (int k = 0; k < MAX_NODES; k++) begin
         if (hop_inc == IDX_W'(k)) nxt_entry = node_q[k];
         if (hop_q == IDX_W'(k))   hop_act   = act_q[k];
      end
      len_ok = (bus.path_len >= IDX_W'(2)) && (bus.path_len <= IDX_W'(MAX_NODES));
   end

   always_comb begin
      state_d  = state_q;
      node_d   = node_q;
      act_d    = act_q;
      len_d    = len_q;
      cur_d    = cur_q;
      next_d   = next_q;
      hop_d    = hop_q;
      action_d = action_q;
      done_d   = done_q;
      err_d    = err_q;

      if (bus.abort) begin
         state_d  = ST_IDLE;
         action_d = FOLLOW_LINE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.load) begin
                  if (len_ok) begin
                     for (int k = 0; k < MAX_NODES; k++) begin
                        node_d[k] = bus.path_in[k*NODE_W +: NODE_W];
                        act_d[k]  = bus.act_in[2*k +: 2];
                     end
                     len_d    = bus.path_len;
                     cur_d    = bus.path_in[0 +: NODE_W];
                     next_d   = bus.path_in[NODE_W +: NODE_W];
                     hop_d    = IDX_W'(1);
                     action_d = FOLLOW_LINE;
                     done_d   = 1'b0;
                     err_d    = 1'b0;
                     state_d  = ST_FOLLOW;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_FOLLOW: begin
               if (bus.load) err_d = 1'b1;
               // A go-straight code is shown for exactly one cycle.
               action_d = FOLLOW_LINE;
               if (ndet_rise) begin
                  cur_d = next_q;
                  if (hop_q == last_idx) begin
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     action_d = hop_act;
                     if (is_turn(hop_act)) begin
                        state_d = ST_TURN;
                     end else begin
                        hop_d  = hop_inc;
                        next_d = nxt_entry;
                     end
                  end
               end
            end
            ST_TURN: begin
               if (bus.load) err_d = 1'b1;
               if (bus.turn_done) begin
                  hop_d    = hop_inc;
                  next_d   = nxt_entry;
                  action_d = FOLLOW_LINE;
                  state_d  = ST_FOLLOW;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state_q == ST_FOLLOW) || (state_q == ST_TURN);
      bus.cur_node  = cur_q;
      bus.next_node = next_q;
      bus.action    = action_q;
      bus.hop_idx   = hop_q;
      bus.done      = done_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_path_node_sequencer.sv
// tb/tb_path_node_sequencer.sv - directed scenarios for the path/hop sequencer with hand-computed expectations
module tb_path_node_sequencer;

   localparam int NODE_W    = 7;
   localparam int MAX_NODES = 37;
   localparam int IDX_W     = $clog2(MAX_NODES + 1);

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [NODE_W*MAX_NODES-1:0] path_v;
   logic [2*MAX_NODES-1:0]      act_v;

   path_node_sequencer_if #(.NODE_W(NODE_W), .MAX_NODES(MAX_NODES)) bus ();

   path_node_sequencer #(.NODE_W(NODE_W), .MAX_NODES(MAX_NODES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_path();
      path_v = '0;
      act_v  = '0;
   endtask

   task automatic set_entry(input int k, input int id, input logic [1:0] a);
      path_v[k*NODE_W +: NODE_W] = id[NODE_W-1:0];
      act_v[2*k +: 2]            = a;
   endtask

   task automatic do_load(input int len);
      bus.path_in  = path_v;
      bus.act_in   = act_v;
      bus.path_len = len[IDX_W-1:0];
      bus.load     = 1'b1;
      tick();
      bus.load     = 1'b0;
   endtask

   task automatic do_abort();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (bus.cur_node !== 7'd0) begin errors++; $display("FAIL rst_cur: got %0d exp 0", bus.cur_node); end
      checks++; if (bus.next_node !== 7'd0) begin errors++; $display("FAIL rst_next: got %0d exp 0", bus.next_node); end
      checks++; if (bus.hop_idx !== 6'd0) begin errors++; $display("FAIL rst_hop: got %0d exp 0", bus.hop_idx); end
      checks++; if ({bus.action, bus.busy, bus.done, bus.err} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b exp 00000", {bus.action, bus.busy, bus.done, bus.err}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_turn();
      clear_path();
      set_entry(0, 33, 2'b00);
      set_entry(1, 5, 2'b01);
      set_entry(2, 3, 2'b00);
      do_load(3);
      checks++; if ({bus.busy, bus.cur_node, bus.next_node, bus.hop_idx, bus.action} !== {1'b1, 7'd33, 7'd5, 6'd1, 2'b00}) begin errors++; $display("FAIL t1_load: busy=%0b cur=%0d next=%0d hop=%0d act=%b exp 1/33/5/1/00", bus.busy, bus.cur_node, bus.next_node, bus.hop_idx, bus.action); end
      bus.node_det = 1'b1;
      tick();
      checks++; if ({bus.action, bus.cur_node, bus.hop_idx} !== {2'b01, 7'd5, 6'd1}) begin errors++; $display("FAIL t1_turn: act=%b cur=%0d hop=%0d exp 01/5/1", bus.action, bus.cur_node, bus.hop_idx); end
      bus.node_det = 1'b0;
      tick();
      bus.turn_done = 1'b1;
      tick();
      bus.turn_done = 1'b0;
      checks++; if ({bus.next_node, bus.hop_idx, bus.action} !== {7'd3, 6'd2, 2'b00}) begin errors++; $display("FAIL t1_tdone: next=%0d hop=%0d act=%b exp 3/2/00", bus.next_node, bus.hop_idx, bus.action); end
      bus.node_det = 1'b1;
      tick();
      bus.node_det = 1'b0;
      checks++; if ({bus.done, bus.busy, bus.cur_node, bus.action} !== {1'b1, 1'b0, 7'd3, 2'b00}) begin errors++; $display("FAIL t1_done: done=%0b busy=%0b cur=%0d act=%b exp 1/0/3/00", bus.done, bus.busy, bus.cur_node, bus.action); end
      tick();
   endtask

   task automatic test_go_straight();
      clear_path();
      for (int k = 0; k < 4; k++) set_entry(k, 10 + k, 2'b10);
      do_load(4);
      for (int h = 1; h < 3; h++) begin
         bus.node_det = 1'b1;
         tick();
         checks++; if ({bus.action, bus.busy, bus.cur_node, bus.next_node, bus.hop_idx} !== {2'b10, 1'b1, 7'(10 + h), 7'(11 + h), 6'(h + 1)}) begin errors++; $display("FAIL t2_hop%0d: act=%b busy=%0b cur=%0d next=%0d hop=%0d", h, bus.action, bus.busy, bus.cur_node, bus.next_node, bus.hop_idx); end
         bus.node_det = 1'b0;
         tick();
         checks++; if ({bus.action, bus.busy} !== {2'b00, 1'b1}) begin errors++; $display("FAIL t2_back%0d: act=%b busy=%0b exp 00/1", h, bus.action, bus.busy); end
      end
      bus.node_det = 1'b1;
      tick();
      bus.node_det = 1'b0;
      checks++; if ({bus.done, bus.busy, bus.cur_node, bus.action} !== {1'b1, 1'b0, 7'd13, 2'b00}) begin errors++; $display("FAIL t2_done: done=%0b busy=%0b cur=%0d act=%b exp 1/0/13/00", bus.done, bus.busy, bus.cur_node, bus.action); end
      tick();
   endtask

   task automatic test_bad_length();
      clear_path();
      set_entry(0, 7, 2'b00);
      set_entry(1, 9, 2'b00);
      do_load(1);
      checks++; if ({bus.err, bus.busy, bus.done, bus.cur_node} !== {1'b1, 1'b0, 1'b1, 7'd13}) begin errors++; $display("FAIL t3_len1: err=%0b busy=%0b done=%0b cur=%0d exp 1/0/1/13", bus.err, bus.busy, bus.done, bus.cur_node); end
      do_load(MAX_NODES + 1);
      checks++; if ({bus.err, bus.busy} !== 2'b10) begin errors++; $display("FAIL t3_len38: err=%0b busy=%0b exp 1/0", bus.err, bus.busy); end
      do_load(2);
      checks++; if ({bus.err, bus.busy, bus.done, bus.cur_node, bus.next_node} !== {3'b010, 7'd7, 7'd9}) begin errors++; $display("FAIL t3_len2: err=%0b busy=%0b done=%0b cur=%0d next=%0d exp 0/1/0/7/9", bus.err, bus.busy, bus.done, bus.cur_node, bus.next_node); end
      do_abort();
   endtask

   task automatic test_node_hold();
      clear_path();
      set_entry(0, 20, 2'b00);
      set_entry(1, 21, 2'b10);
      set_entry(2, 22, 2'b11);
      set_entry(3, 23, 2'b00);
      do_load(4);
      bus.turn_done = 1'b1;
      tick();
      bus.turn_done = 1'b0;
      checks++; if ({bus.hop_idx, bus.next_node} !== {6'd1, 7'd21}) begin errors++; $display("FAIL t4_tdone_follow: hop=%0d next=%0d exp 1/21", bus.hop_idx, bus.next_node); end
      bus.node_det = 1'b1;
      repeat (10) tick();
      bus.node_det = 1'b0;
      checks++; if ({bus.hop_idx, bus.cur_node, bus.next_node, bus.action} !== {6'd2, 7'd21, 7'd22, 2'b00}) begin errors++; $display("FAIL t4_hold: hop=%0d cur=%0d next=%0d act=%b exp 2/21/22/00", bus.hop_idx, bus.cur_node, bus.next_node, bus.action); end
      tick();
      bus.node_det = 1'b1;
      tick();
      bus.node_det = 1'b0;
      checks++; if ({bus.action, bus.cur_node, bus.hop_idx} !== {2'b11, 7'd22, 6'd2}) begin errors++; $display("FAIL t4_turn: act=%b cur=%0d hop=%0d exp 11/22/2", bus.action, bus.cur_node, bus.hop_idx); end
      tick();
      bus.node_det = 1'b1;
      tick();
      bus.node_det = 1'b0;
      tick();
      checks++; if ({bus.action, bus.cur_node, bus.next_node, bus.hop_idx, bus.busy} !== {2'b11, 7'd22, 7'd22, 6'd2, 1'b1}) begin errors++; $display("FAIL t4_turn_ndet: act=%b cur=%0d next=%0d hop=%0d busy=%0b exp 11/22/22/2/1", bus.action, bus.cur_node, bus.next_node, bus.hop_idx, bus.busy); end
   endtask

   task automatic test_abort();
      clear_path();
      set_entry(0, 40, 2'b00);
      set_entry(1, 41, 2'b00);
      set_entry(2, 42, 2'b00);
      bus.abort     = 1'b1;
      bus.turn_done = 1'b1;
      do_load(3);
      bus.abort     = 1'b0;
      bus.turn_done = 1'b0;
      checks++; if ({bus.busy, bus.action, bus.err, bus.hop_idx, bus.cur_node} !== {1'b0, 2'b00, 1'b0, 6'd2, 7'd22}) begin errors++; $display("FAIL t5_abort: busy=%0b act=%b err=%0b hop=%0d cur=%0d exp 0/00/0/2/22", bus.busy, bus.action, bus.err, bus.hop_idx, bus.cur_node); end
      do_load(3);
      checks++; if ({bus.busy, bus.cur_node, bus.next_node} !== {1'b1, 7'd40, 7'd41}) begin errors++; $display("FAIL t5_reload: busy=%0b cur=%0d next=%0d exp 1/40/41", bus.busy, bus.cur_node, bus.next_node); end
      clear_path();
      set_entry(0, 50, 2'b00);
      set_entry(1, 51, 2'b00);
      do_load(2);
      checks++; if ({bus.err, bus.busy, bus.cur_node, bus.next_node, bus.hop_idx} !== {2'b11, 7'd40, 7'd41, 6'd1}) begin errors++; $display("FAIL t5_busy_load: err=%0b busy=%0b cur=%0d next=%0d hop=%0d exp 1/1/40/41/1", bus.err, bus.busy, bus.cur_node, bus.next_node, bus.hop_idx); end
      do_abort();
   endtask

   task automatic test_async_reset_and_full();
      clear_path();
      set_entry(0, 33, 2'b00);
      set_entry(1, 5, 2'b01);
      set_entry(2, 3, 2'b00);
      do_load(3);
      bus.node_det = 1'b1;
      tick();
      bus.node_det = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if ({bus.cur_node, bus.next_node, bus.hop_idx, bus.action, bus.busy, bus.done, bus.err} !== 25'd0) begin errors++; $display("FAIL t6_async_rst: cur=%0d next=%0d hop=%0d act=%b busy=%0b done=%0b err=%0b exp all 0", bus.cur_node, bus.next_node, bus.hop_idx, bus.action, bus.busy, bus.done, bus.err); end
      #1;
      rst = 1'b0;
      tick();
      clear_path();
      for (int k = 0; k < MAX_NODES; k++) set_entry(k, k + 1, 2'b00);
      do_load(MAX_NODES);
      for (int h = 1; h < MAX_NODES - 1; h++) begin
         bus.node_det = 1'b1;
         tick();
         bus.node_det = 1'b0;
         tick();
      end
      checks++; if ({bus.hop_idx, bus.next_node, bus.cur_node, bus.busy} !== {6'd36, 7'd37, 7'd36, 1'b1}) begin errors++; $display("FAIL t6_full_last: hop=%0d next=%0d cur=%0d busy=%0b exp 36/37/36/1", bus.hop_idx, bus.next_node, bus.cur_node, bus.busy); end
      bus.node_det = 1'b1;
      tick();
      bus.node_det = 1'b0;
      checks++; if ({bus.hop_idx, bus.cur_node, bus.done, bus.busy} !== {6'd36, 7'd37, 1'b1, 1'b0}) begin errors++; $display("FAIL t6_full_done: hop=%0d cur=%0d done=%0b busy=%0b exp 36/37/1/0", bus.hop_idx, bus.cur_node, bus.done, bus.busy); end
      tick();
   endtask

   initial begin
      rst           = 1'b1;
      bus.path_in   = '0;
      bus.act_in    = '0;
      bus.path_len  = '0;
      bus.load      = 1'b0;
      bus.abort     = 1'b0;
      bus.node_det  = 1'b0;
      bus.turn_done = 1'b0;
      test_reset();
      test_basic_turn();
      test_go_straight();
      test_bad_length();
      test_node_hold();
      test_abort();
      test_async_reset_and_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
